// File: rtl/y86_pkg.sv
// y86_pkg: shared constants for the Y86-64 writeback stage.
//   - status codes (AOK, HLT, ADR, INS)
//   - instruction codes
//   - register IDs (RSP, RNONE)
//   - writeback state enum
package y86_pkg;

    localparam logic [2:0] StatAok = 3'd1;
    localparam logic [2:0] StatHlt = 3'd2;
    localparam logic [2:0] StatAdr = 3'd3;
    localparam logic [2:0] StatIns = 3'd4;

    localparam logic [3:0] IHalt   = 4'h0;
    localparam logic [3:0] INop    = 4'h1;
    localparam logic [3:0] IRrmovq = 4'h2;
    localparam logic [3:0] IIrmovq = 4'h3;
    localparam logic [3:0] IRmmovq = 4'h4;
    localparam logic [3:0] IMrmovq = 4'h5;
    localparam logic [3:0] IOpq    = 4'h6;
    localparam logic [3:0] IJxx    = 4'h7;
    localparam logic [3:0] ICall   = 4'h8;
    localparam logic [3:0] IRet    = 4'h9;
    localparam logic [3:0] IPushq  = 4'hA;
    localparam logic [3:0] IPopq   = 4'hB;

    localparam logic [3:0] RegRsp  = 4'h4;
    localparam logic [3:0] RegNone = 4'hF;

    typedef enum logic {
        StRun,
        StHalted
    } wb_state_e;

endpackage

// File: rtl/wb_dst_decode.sv
// wb_dst_decode: combinational register-file destination decode.
// Ports:
//   i_icode  instruction code
//   i_ra     rA field
//   i_rb     rB field
//   i_cnd    condition result (cmovXX)
//   o_dst_e  destination for valE (RNONE if none)
//   o_dst_m  destination for valM (RNONE if none)
module wb_dst_decode
    import y86_pkg::*;
(
    input  logic [3:0] i_icode,
    input  logic [3:0] i_ra,
    input  logic [3:0] i_rb,
    input  logic       i_cnd,
    output logic [3:0] o_dst_e,
    output logic [3:0] o_dst_m
);

    always_comb begin
        o_dst_e = RegNone;
        o_dst_m = RegNone;
        case (i_icode)
            IRrmovq:               o_dst_e = i_cnd ? i_rb : RegNone;
            IIrmovq, IOpq:         o_dst_e = i_rb;
            IMrmovq:               o_dst_m = i_ra;
            IPopq: begin
                o_dst_m = i_ra;
                o_dst_e = RegRsp;
            end
            IPushq, ICall, IRet:   o_dst_e = RegRsp;
            default: begin
                o_dst_e = RegNone;
                o_dst_m = RegNone;
            end
        endcase
    end

endmodule

// File: rtl/writeback_reg.sv
// writeback_reg: memory-to-writeback pipeline register for the Y86-64 core.
// Captures the M bundle each cycle under stall/bubble control, drives the
// register-file write ports and owns the processor halt state.
// Optional feature: define WB_RETIRE_CNT_EN to add the 64-bit retired counter.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   mstat..mvalM            memory-stage bundle
//   w_stall, w_bubble       pipeline control (stall wins)
//   wstat..wvalM, wvalid    W register contents
//   rf_weE, rf_weM          register-file write enables
//   halted                  core halted
//   retired                 retired-instruction count (WB_RETIRE_CNT_EN only)
module writeback_reg
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  mstat,
    input  logic [3:0]  micode,
    input  logic [3:0]  mrA,
    input  logic [3:0]  mrB,
    input  logic        mcnd,
    input  logic [63:0] mvalE,
    input  logic [63:0] mvalM,
    input  logic        w_stall,
    input  logic        w_bubble,
    output logic [2:0]  wstat,
    output logic [3:0]  wicode,
    output logic        wvalid,
    output logic [3:0]  wdstE,
    output logic [3:0]  wdstM,
    output logic [63:0] wvalE,
    output logic [63:0] wvalM,
    output logic        rf_weE,
    output logic        rf_weM,
    output logic        halted
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0] retired
`endif
);

    wb_state_e   r_state;
    logic [2:0]  r_stat;
    logic [3:0]  r_icode;
    logic        r_valid;
    logic [3:0]  r_dst_e;
    logic [3:0]  r_dst_m;
    logic [63:0] r_val_e;
    logic [63:0] r_val_m;

    logic [3:0]  w_dst_e;
    logic [3:0]  w_dst_m;

    wb_dst_decode u_dst_decode (
        .i_icode (micode),
        .i_ra    (mrA),
        .i_rb    (mrB),
        .i_cnd   (mcnd),
        .o_dst_e (w_dst_e),
        .o_dst_m (w_dst_m)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StRun;
            r_stat  <= StatAok;
            r_icode <= INop;
            r_valid <= 1'b0;
            r_dst_e <= RegNone;
            r_dst_m <= RegNone;
            r_val_e <= 64'd0;
            r_val_m <= 64'd0;
        end else if (r_state == StRun && !w_stall) begin
            if (w_bubble) begin
                r_stat  <= StatAok;
                r_icode <= INop;
                r_valid <= 1'b0;
                r_dst_e <= RegNone;
                r_dst_m <= RegNone;
                r_val_e <= 64'd0;
                r_val_m <= 64'd0;
            end else begin
                r_stat  <= mstat;
                r_icode <= micode;
                r_valid <= 1'b1;
                r_dst_e <= w_dst_e;
                r_dst_m <= w_dst_m;
                r_val_e <= mvalE;
                r_val_m <= mvalM;
                // Only a real load of a faulting instruction halts the core.
                if (mstat != StatAok) r_state <= StHalted;
            end
        end
    end

    assign wstat  = r_stat;
    assign wicode = r_icode;
    assign wvalid = r_valid;
    assign wdstE  = r_dst_e;
    assign wdstM  = r_dst_m;
    assign wvalE  = r_val_e;
    assign wvalM  = r_val_m;
    assign halted = (r_state == StHalted);

    // Non-AOK content in W never writes the register file.
    assign rf_weE = r_valid && (r_stat == StatAok) && (r_dst_e != RegNone);
    assign rf_weM = r_valid && (r_stat == StatAok) && (r_dst_m != RegNone);

`ifdef WB_RETIRE_CNT_EN
    // r_loaded marks that W received a new instruction on the last edge, so a
    // stalled instruction is counted only once.
    logic        r_loaded;
    logic [63:0] r_retired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loaded  <= 1'b0;
            r_retired <= 64'd0;
        end else begin
            r_loaded <= (r_state == StRun) && !w_stall && !w_bubble;
            if (r_state == StRun && r_loaded && r_valid && r_stat == StatAok) begin
                r_retired <= r_retired + 64'd1;
            end
        end
    end

    assign retired = r_retired;
`endif

endmodule

// File: tb/tb_writeback_reg.sv
module tb_writeback_reg;

    logic        clk;
    logic        rst_n;
    logic [2:0]  mstat;
    logic [3:0]  micode;
    logic [3:0]  mrA;
    logic [3:0]  mrB;
    logic        mcnd;
    logic [63:0] mvalE;
    logic [63:0] mvalM;
    logic        w_stall;
    logic        w_bubble;
    logic [2:0]  wstat;
    logic [3:0]  wicode;
    logic        wvalid;
    logic [3:0]  wdstE;
    logic [3:0]  wdstM;
    logic [63:0] wvalE;
    logic [63:0] wvalM;
    logic        rf_weE;
    logic        rf_weM;
    logic        halted;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retired;
`endif

    writeback_reg dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mstat    (mstat),
        .micode   (micode),
        .mrA      (mrA),
        .mrB      (mrB),
        .mcnd     (mcnd),
        .mvalE    (mvalE),
        .mvalM    (mvalM),
        .w_stall  (w_stall),
        .w_bubble (w_bubble),
        .wstat    (wstat),
        .wicode   (wicode),
        .wvalid   (wvalid),
        .wdstE    (wdstE),
        .wdstM    (wdstM),
        .wvalE    (wvalE),
        .wvalM    (wvalM),
        .rf_weE   (rf_weE),
        .rf_weM   (rf_weM),
        .halted   (halted)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retired  (retired)
`endif
    );

    typedef struct {
        string       name;
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic        valid;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
        logic [63:0] val_e;
        logic [63:0] val_m;
        logic        we_e;
        logic        we_m;
        logic        halt;
        logic [63:0] ret;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input string field,
                       input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", name, field, act, req);
        end
    endtask

    // Monitor: W is presented every cycle; compare just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.name, "wstat",  {61'd0, wstat},  {61'd0, e.stat});
                chk(e.name, "wicode", {60'd0, wicode}, {60'd0, e.icode});
                chk(e.name, "wvalid", {63'd0, wvalid}, {63'd0, e.valid});
                chk(e.name, "wdstE",  {60'd0, wdstE},  {60'd0, e.dst_e});
                chk(e.name, "wdstM",  {60'd0, wdstM},  {60'd0, e.dst_m});
                chk(e.name, "wvalE",  wvalE,           e.val_e);
                chk(e.name, "wvalM",  wvalM,           e.val_m);
                chk(e.name, "rf_weE", {63'd0, rf_weE}, {63'd0, e.we_e});
                chk(e.name, "rf_weM", {63'd0, rf_weM}, {63'd0, e.we_m});
                chk(e.name, "halted", {63'd0, halted}, {63'd0, e.halt});
`ifdef WB_RETIRE_CNT_EN
                chk(e.name, "retired", retired, e.ret);
`endif
            end
        end
    end

    // One stimulus step: drive on the falling edge, push the W state expected
    // right after the next rising edge.
    task automatic step(input string name, input logic rst, input logic stall,
                        input logic bubble, input logic [2:0] st, input logic [3:0] ic,
                        input logic [3:0] ra, input logic [3:0] rb, input logic cnd,
                        input logic [63:0] ve, input logic [63:0] vm,
                        input logic [2:0] x_stat, input logic [3:0] x_icode,
                        input logic x_valid, input logic [3:0] x_de, input logic [3:0] x_dm,
                        input logic [63:0] x_ve, input logic [63:0] x_vm,
                        input logic x_wee, input logic x_wem, input logic x_halt,
                        input logic [63:0] x_ret);
        exp_t e;
        @(negedge clk);
        rst_n = rst; w_stall = stall; w_bubble = bubble;
        mstat = st; micode = ic; mrA = ra; mrB = rb; mcnd = cnd; mvalE = ve; mvalM = vm;
        e.name = name; e.stat = x_stat; e.icode = x_icode; e.valid = x_valid;
        e.dst_e = x_de; e.dst_m = x_dm; e.val_e = x_ve; e.val_m = x_vm;
        e.we_e = x_wee; e.we_m = x_wem; e.halt = x_halt; e.ret = x_ret;
        q.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0; w_stall = 1'b0; w_bubble = 1'b0;
        mstat = 3'd1; micode = 4'h1; mrA = 4'hF; mrB = 4'hF; mcnd = 1'b0;
        mvalE = 64'd0; mvalM = 64'd0;

        //   name        rst stl bub st ic  rA  rB cnd valE     valM     | stat ic val dE  dM  vE       vM     weE weM hlt ret
        step("reset0",   0, 0, 0, 1, 4'h6, 4'hF, 4'h3, 0, 64'h2A, 64'h0,  1, 4'h1, 0, 4'hF, 4'hF, 64'h0,   64'h0,  0, 0, 0, 0);
        step("opq",      1, 0, 0, 1, 4'h6, 4'hF, 4'h3, 0, 64'h2A, 64'h0,  1, 4'h6, 1, 4'h3, 4'hF, 64'h2A,  64'h0,  1, 0, 0, 0);
        step("popq",     1, 0, 0, 1, 4'hB, 4'h5, 4'hF, 0, 64'h100, 64'h77, 1, 4'hB, 1, 4'h4, 4'h5, 64'h100, 64'h77, 1, 1, 0, 1);
        step("cmov_nt",  1, 0, 0, 1, 4'h2, 4'h1, 4'h7, 0, 64'h9,  64'h0,  1, 4'h2, 1, 4'hF, 4'hF, 64'h9,   64'h0,  0, 0, 0, 2);
        step("stl_bub",  1, 1, 1, 1, 4'h3, 4'hF, 4'h8, 0, 64'h55, 64'h0,  1, 4'h2, 1, 4'hF, 4'hF, 64'h9,   64'h0,  0, 0, 0, 3);
        step("bubble",   1, 0, 1, 1, 4'h3, 4'hF, 4'h8, 0, 64'h55, 64'h0,  1, 4'h1, 0, 4'hF, 4'hF, 64'h0,   64'h0,  0, 0, 0, 3);
        step("stall",    1, 1, 0, 1, 4'h6, 4'hF, 4'h2, 0, 64'h66, 64'h0,  1, 4'h1, 0, 4'hF, 4'hF, 64'h0,   64'h0,  0, 0, 0, 3);
        step("mrm_adr",  1, 0, 0, 3, 4'h5, 4'h2, 4'hF, 0, 64'h40, 64'h0,  3, 4'h5, 1, 4'hF, 4'h2, 64'h40,  64'h0,  0, 0, 1, 3);
        step("hlt_opq",  1, 0, 0, 1, 4'h6, 4'hF, 4'h3, 0, 64'h2A, 64'h0,  3, 4'h5, 1, 4'hF, 4'h2, 64'h40,  64'h0,  0, 0, 1, 3);
        step("hlt_bub",  1, 0, 1, 1, 4'h6, 4'hF, 4'h3, 0, 64'h2A, 64'h0,  3, 4'h5, 1, 4'hF, 4'h2, 64'h40,  64'h0,  0, 0, 1, 3);
        step("reset1",   0, 0, 0, 1, 4'h6, 4'hF, 4'h3, 0, 64'h2A, 64'h0,  1, 4'h1, 0, 4'hF, 4'hF, 64'h0,   64'h0,  0, 0, 0, 0);
        step("irmovq",   1, 0, 0, 1, 4'h3, 4'hF, 4'h8, 0, 64'h5,  64'h0,  1, 4'h3, 1, 4'h8, 4'hF, 64'h5,   64'h0,  1, 0, 0, 0);
        step("cmov_t",   1, 0, 0, 1, 4'h2, 4'h1, 4'h6, 1, 64'h11, 64'h0,  1, 4'h2, 1, 4'h6, 4'hF, 64'h11,  64'h0,  1, 0, 0, 1);
        step("halt_hlt", 1, 0, 0, 2, 4'h0, 4'hF, 4'hF, 0, 64'h0,  64'h0,  2, 4'h0, 1, 4'hF, 4'hF, 64'h0,   64'h0,  0, 0, 1, 2);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/writeback_reg.md
# writeback_reg

Memory-to-writeback pipeline register for the Y86-64 pipelined core. Captures the memory-stage bundle each cycle, honours stall/bubble control from the pipeline controller, derives register-file destinations, and drives the register-file write ports. Owns the processor halt state: after an instruction with a non-AOK status enters writeback, the register freezes and the core reports halted until reset.

## Interface
Parameters: none.

Ports:
- clk  in  1  core clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mstat  in  3  memory-stage status, already merged with data-memory error
- micode  in  4  memory-stage icode
- mrA  in  4  rA field
- mrB  in  4  rB field
- mcnd  in  1  condition result (cmovXX)
- mvalE  in  64  ALU result
- mvalM  in  64  data-memory read data
- w_stall  in  1  hold W contents
- w_bubble  in  1  load NOP bubble
- wstat  out  3  W status
- wicode  out  4  W icode
- wvalid  out  1  W holds a real (non-bubble) instruction
- wdstE, wdstM  out  4  W destinations (RNONE=0xF if none)
- wvalE, wvalM  out  64  W values
- rf_weE, rf_weM  out  1  register-file write enables
- halted  out  1  core halted
- retired  out  64  retired-instruction count (only with WB_RETIRE_CNT_EN)

## Operation
- States: RUN, HALTED. Reset to RUN.
- Destination decode (from micode, mrA, mrB, mcnd):
  - rrmovq/cmovXX (2): dstE = mcnd ? mrB : RNONE
  - irmovq (3), OPq (6): dstE = mrB
  - mrmovq (5): dstM = mrA
  - popq (B): dstM = mrA, dstE = RSP (4)
  - pushq (A), call (8), ret (9): dstE = RSP
  - all others: both RNONE
- Load priority in RUN: w_stall (hold all) > w_bubble (stat AOK, icode NOP, dst RNONE, vals 0, wvalid 0) > normal load (wvalid 1).
- RUN -> HALTED on the edge that normally loads mstat != AOK (HLT=2, ADR=3, INS=4). Stall/bubble never cause the transition.
- HALTED: W contents frozen regardless of w_stall/w_bubble; exit only via rst_n.
- rf_weE = wvalid && wstat==AOK && wdstE!=RNONE; rf_weM likewise with wdstM. Both forced 0 for non-AOK W content, so the faulting instruction never writes.
- halted = (state == HALTED).
- Reset values: wstat AOK (1), wicode NOP (1), wdstE/wdstM RNONE, wvalE/wvalM 0, wvalid 0, state RUN, retired 0.

## Timing
- One-cycle latency: inputs on edge N appear on W outputs after edge N; register-file write occurs on edge N+1.
- rf_we* and halted are combinational from registered state only; no input-to-output combinational path.
- halted asserts in the same cycle the faulting instruction is visible in W.
- Stall and bubble together: stall wins.
- Asynchronous reset mid-operation clears everything immediately, including HALTED.

## Configuration
- WB_RETIRE_CNT_EN defined: 64-bit retired counter increments on each edge where state is RUN, wvalid=1 and wstat=AOK. It counts the instruction currently in W, so a stall cycle counts it once more unless gated by a change-of-W flag; the implementation shall count each instruction once, tracking loads with a single internal bit. Wraps modulo 2^64. Frozen in HALTED.
- Undefined: retired port and counter absent.

## Structure
- y86_pkg: stat codes (AOK, HLT, ADR, INS), icode constants, RNONE, RSP, state enum.
- Sub-module wb_dst_decode: combinational icode/rA/rB/cnd -> dstE/dstM.

## Test plan
- Reset: rst_n low mid-stream -> wicode=1, wstat=1, rf_weE=rf_weM=0, halted=0, retired=0.
- OPq micode=6, mrB=3, mvalE=0x2A -> next cycle wdstE=3, rf_weE=1, wvalE=0x2A; rf_weM=0.
- popq micode=B, mrA=5, mvalE=0x100, mvalM=0x77 -> wdstE=4, wdstM=5, both enables 1.
- cmovXX with mcnd=0 -> wdstE=0xF, rf_weE=0; w_stall and w_bubble together -> W unchanged.
- mrmovq with mstat=ADR(3) -> rf_weM=0, halted=1; subsequent loads of AOK OPq are ignored and W stays frozen until rst_n.
- With WB_RETIRE_CNT_EN: 3 AOK instructions, 1 bubble, 2 stall cycles, then HLT -> retired=3.
